// File: rtl/xoroshiro128ss_axis_if.sv
`default_nettype none
// ============================================================================
// Module      : xoroshiro128ss_axis_if
// Description : AXI4-Stream bundle carried by the multi-lane xoroshiro128**
//               payload source. tdata holds NUM_LANES 64-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
interface xoroshiro128ss_axis_if #(
    parameter int NUM_LANES = 1
);
    logic [64*NUM_LANES-1:0] tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/xoroshiro128ss_axis.sv
`default_nettype none
// ============================================================================
// Module      : xoroshiro128ss_axis
// Description : NUM_LANES independent xoroshiro128** generators packed into
//               one AXI4-Stream master beat, with backpressure, run-time
//               reseeding, an enable gate and optional TLAST framing.
// Revision    : 1.0 - initial release
// ============================================================================
module xoroshiro128ss_axis #(
    parameter int          NUM_LANES = 1,
    parameter logic [63:0] SEED0     = 64'd1,
    parameter logic [63:0] SEED1     = 64'd2,
    parameter int          PKT_LEN   = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             enable,
    input  wire logic             seed_valid,
    input  wire logic [127:0]     seed_data,
    xoroshiro128ss_axis_if.master m_axis
);

    // Per-lane decorrelation steps applied to the base seed pair
    localparam logic [63:0] c_lane_step0 = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] c_lane_step1 = 64'hBF58476D1CE4E5B9;
    // Counter value of the last beat of a packet (unused when unframed)
    localparam logic [15:0] c_last_cnt   = 16'(PKT_LEN - 1);
    localparam logic        c_framed     = (PKT_LEN != 0);

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int k);
        return (x << k) | (x >> (64 - k));
    endfunction

    // Scrambled output: rotl(s0*5, 7) * 9
    function automatic logic [63:0] gen_out(input logic [63:0] s0);
        logic [63:0] w_p;
        w_p = s0 * 64'd5;
        w_p = rotl64(w_p, 7);
        return w_p * 64'd9;
    endfunction

    // Returns {s1', s0'}
    function automatic logic [127:0] gen_next(input logic [63:0] s0,
                                              input logic [63:0] s1);
        logic [63:0] w_t;
        w_t = s0 ^ s1;
        return {rotl64(w_t, 37), rotl64(s0, 24) ^ w_t ^ (w_t << 16)};
    endfunction

    // Returns {s1, s0} for a lane; an all-zero state would lock up, so s1 is forced to 1
    function automatic logic [127:0] lane_seed(input logic [63:0] b0,
                                               input logic [63:0] b1,
                                               input int          lane);
        logic [63:0] w_s0;
        logic [63:0] w_s1;
        w_s0 = b0 ^ (64'(lane) * c_lane_step0);
        w_s1 = b1 ^ (64'(lane) * c_lane_step1);
        if (w_s0 == 64'd0 && w_s1 == 64'd0) begin
            w_s1 = 64'd1;
        end
        return {w_s1, w_s0};
    endfunction

    logic                    r_tvalid;
    logic [15:0]             r_cnt;
    logic [64*NUM_LANES-1:0] w_tdata;
    logic                    w_load;
    logic                    w_hs;
    logic                    w_tlast;

    // A new beat may be loaded when the register is empty or being drained
    assign w_load  = enable && (!r_tvalid || m_axis.tready);
    assign w_hs    = r_tvalid && m_axis.tready;
    assign w_tlast = c_framed && (r_cnt == c_last_cnt);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [63:0]  r_s0;
            logic [63:0]  r_s1;
            logic [63:0]  r_word;
            logic [127:0] w_rst_seed;
            logic [127:0] w_new_seed;
            logic [127:0] w_next;

            assign w_rst_seed = lane_seed(SEED0, SEED1, gi);
            assign w_new_seed = lane_seed(seed_data[63:0], seed_data[127:64], gi);
            assign w_next     = gen_next(r_s0, r_s1);

            // Generator state: reset seed, then reseed, then advance on load
            always_ff @(posedge clk) begin
                if (rst) begin
                    {r_s1, r_s0} <= w_rst_seed;
                end else if (seed_valid) begin
                    {r_s1, r_s0} <= w_new_seed;
                end else if (w_load) begin
                    {r_s1, r_s0} <= w_next;
                end
            end

            // Output word captures the pre-advance state, frozen otherwise
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_load) begin
                    r_word <= gen_out(r_s0);
                end
            end

            assign w_tdata[64*gi +: 64] = r_word;
        end
    endgenerate

    // Valid: set on load, cleared only when a beat drains while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
        end else if (w_hs && !enable) begin
            r_tvalid <= 1'b0;
        end
    end

    // Beat counter: wraps after the tlast beat, free-runs when unframed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if (w_hs) begin
            if (w_tlast) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign m_axis.tdata  = w_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = w_tlast;

endmodule
`default_nettype wire

// File: tb/tb_xoroshiro128ss_axis.sv
`default_nettype none
// ============================================================================
// Module      : tb_xoroshiro128ss_axis
// Description : Self-checking bench: single-lane unframed instance and a
//               four-lane PKT_LEN=3 instance against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xoroshiro128ss_axis;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_en = 1'b1;
    logic         a_sv = 1'b0;
    logic [127:0] a_sd = '0;
    logic         b_en = 1'b1;
    logic         b_sv = 1'b0;
    logic [127:0] b_sd = '0;

    xoroshiro128ss_axis_if #(.NUM_LANES(1)) a_if ();
    xoroshiro128ss_axis_if #(.NUM_LANES(4)) b_if ();

    xoroshiro128ss_axis #(.NUM_LANES(1), .PKT_LEN(0)) u_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (a_en),
        .seed_valid (a_sv),
        .seed_data  (a_sd),
        .m_axis     (a_if)
    );

    xoroshiro128ss_axis #(.NUM_LANES(4), .PKT_LEN(3)) u_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (b_en),
        .seed_valid (b_sv),
        .seed_data  (b_sd),
        .m_axis     (b_if)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model
    function automatic logic [63:0] rl(input logic [63:0] x, input int k);
        return (x << k) | (x >> (64 - k));
    endfunction

    function automatic logic [63:0] mout(input logic [63:0] s0);
        logic [63:0] p;
        p = s0 * 64'd5;
        p = rl(p, 7);
        return p * 64'd9;
    endfunction

    function automatic logic [127:0] mnext(input logic [63:0] s0, input logic [63:0] s1);
        logic [63:0] t;
        t = s0 ^ s1;
        return {rl(t, 37), rl(s0, 24) ^ t ^ (t << 16)};
    endfunction

    function automatic logic [127:0] mseed(input logic [63:0] b0, input logic [63:0] b1, input int lane);
        logic [63:0] s0;
        logic [63:0] s1;
        s0 = b0 ^ (64'(lane) * 64'h9E3779B97F4A7C15);
        s1 = b1 ^ (64'(lane) * 64'hBF58476D1CE4E5B9);
        if (s0 == 64'd0 && s1 == 64'd0) s1 = 64'd1;
        return {s1, s0};
    endfunction

    logic [63:0] a_s0, a_s1;
    logic [63:0] b_s0 [4];
    logic [63:0] b_s1 [4];
    logic        a_pend = 1'b0;
    logic        b_pend = 1'b0;

    task automatic a_seed(input logic [63:0] b0, input logic [63:0] b1);
        {a_s1, a_s0} = mseed(b0, b1, 0);
    endtask

    task automatic a_step();
        {a_s1, a_s0} = mnext(a_s0, a_s1);
    endtask

    task automatic b_seed(input logic [63:0] b0, input logic [63:0] b1);
        for (int l = 0; l < 4; l++) {b_s1[l], b_s0[l]} = mseed(b0, b1, l);
    endtask

    task automatic b_step();
        for (int l = 0; l < 4; l++) {b_s1[l], b_s0[l]} = mnext(b_s0[l], b_s1[l]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] bexp;
        logic         uniq;
        logic         held;
        logic [63:0]  held_d;
        logic         r;

        a_if.tready = 1'b1;
        b_if.tready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("a_rst_tvalid", a_if.tvalid, 1'b0);
        chk("a_rst_tdata",  a_if.tdata,  64'd0);
        chk("a_rst_tlast",  a_if.tlast,  1'b0);
        chk("b_rst_tvalid", b_if.tvalid, 1'b0);
        chk("b_rst_tdata",  b_if.tdata,  256'd0);
        a_seed(64'd1, 64'd2);
        b_seed(64'd1, 64'd2);
        rst = 1'b0;

        // Free-running streams from reset; B reseeds mid-packet
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("a_tvalid", a_if.tvalid, 1'b1);
            if (j == 0) chk("a_beat0_const", a_if.tdata, 64'h0000_0000_0000_1680);
            if (j == 1) chk("a_beat1_const", a_if.tdata, 64'h0000_0016_C380_4380);
            chk("a_beat", a_if.tdata, mout(a_s0));
            chk("a_tlast_unframed", a_if.tlast, 1'b0);
            a_step();

            bexp = '0;
            for (int l = 0; l < 4; l++) bexp[64*l +: 64] = mout(b_s0[l]);
            chk("b_tdata", b_if.tdata, bexp);
            chk("b_tlast", b_if.tlast, ((j % 3) == 2));
            uniq = 1'b1;
            for (int p = 0; p < 4; p++)
                for (int q = p + 1; q < 4; q++)
                    if (b_if.tdata[64*p +: 64] == b_if.tdata[64*q +: 64]) uniq = 1'b0;
            chk("b_lanes_distinct", uniq, 1'b1);
            b_step();
            if (b_pend) begin
                b_seed(64'd1, 64'd2);
                b_pend = 1'b0;
            end
            if (j == 4) begin
                b_sv   = 1'b1;
                b_sd   = {64'd2, 64'd1};
                b_pend = 1'b1;
            end else begin
                b_sv = 1'b0;
            end
        end

        // Random backpressure on A: accepted sequence and hold stability
        held = 1'b0;
        held_d = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (held) begin
                chk("bp_hold_tvalid", a_if.tvalid, 1'b1);
                chk("bp_hold_tdata",  a_if.tdata,  held_d);
            end
            r = (i == 39) ? 1'b1 : 1'($urandom_range(0, 1));
            a_if.tready = r;
            if (a_if.tvalid && r) begin
                chk("bp_beat", a_if.tdata, mout(a_s0));
                a_step();
            end
            held   = a_if.tvalid && !r;
            held_d = a_if.tdata;
        end

        // Reseed with {2,1}: beat at the reseed edge is old, next is 0x1680
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 3) chk("rs_new0_const", a_if.tdata, 64'h0000_0000_0000_1680);
            if (j == 4) chk("rs_new1_const", a_if.tdata, 64'h0000_0016_C380_4380);
            chk("rs_beat", a_if.tdata, mout(a_s0));
            a_step();
            if (a_pend) begin
                a_seed(a_sd[63:0], a_sd[127:64]);
                a_pend = 1'b0;
            end
            if (j == 1) begin
                a_sv   = 1'b1;
                a_sd   = {64'd2, 64'd1};
                a_pend = 1'b1;
            end else begin
                a_sv = 1'b0;
            end
        end

        // Zero seed: lane 0 runs from s0=0, s1=1
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j == 2) chk("z_beat0_const", a_if.tdata, 64'd0);
            if (j == 3) chk("z_beat1_const", a_if.tdata, 64'h0000_0000_1680_1680);
            if (j >= 3) chk("z_nonzero", (a_if.tdata != 64'd0), 1'b1);
            chk("z_beat", a_if.tdata, mout(a_s0));
            a_step();
            if (a_pend) begin
                a_seed(a_sd[63:0], a_sd[127:64]);
                a_pend = 1'b0;
            end
            if (j == 0) begin
                a_sv   = 1'b1;
                a_sd   = '0;
                a_pend = 1'b1;
            end else begin
                a_sv = 1'b0;
            end
        end

        // Enable dropped while a beat is held
        @(negedge clk);
        chk("en_beat", a_if.tdata, mout(a_s0));
        a_if.tready = 1'b0;
        a_en        = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("en_hold_tvalid", a_if.tvalid, 1'b1);
            chk("en_hold_tdata",  a_if.tdata,  mout(a_s0));
        end
        a_if.tready = 1'b1;
        a_step();
        @(negedge clk);
        chk("en_drop_tvalid", a_if.tvalid, 1'b0);
        @(negedge clk);
        chk("en_idle_tvalid", a_if.tvalid, 1'b0);
        a_en = 1'b1;
        @(negedge clk);
        chk("en_resume_tvalid", a_if.tvalid, 1'b1);
        chk("en_resume_tdata",  a_if.tdata,  mout(a_s0));
        a_step();

        // Reset mid-stream
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_a_tvalid", a_if.tvalid, 1'b0);
        chk("mrst_a_tdata",  a_if.tdata,  64'd0);
        chk("mrst_b_tvalid", b_if.tvalid, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk("mrst_a_beat0", a_if.tdata, 64'h0000_0000_0000_1680);
                chk("mrst_b_lane0", b_if.tdata[63:0], 64'h0000_0000_0000_1680);
            end
            chk("mrst_b_tlast", b_if.tlast, (j == 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
